// File: rtl/mono_conf_driver.sv
// mono_conf_driver
//   Serialises a bit stream held in a byte-wide source memory into a chip
//   configuration shift register, reads the chip's serial output back into a
//   byte-wide readback memory, then pulses either the global-register load
//   (LdDAC) or the pixel-latch load (LdPix).
//
// Ports
//   Clk, nRST            system clock, asynchronous active-low reset
//   START                one-cycle request (ignored while BUSY)
//   SEL_PIX, EN_SR_RST   load target / pre-shift reset enable, sampled at START
//   NBITS                number of bits to shift (0..4644), sampled at START
//   BUSY, DONE           transfer in progress / one-cycle completion pulse
//   MEM_RD/ADDR/DATA     source byte read port (data one cycle after MEM_RD)
//   RB_WE/ADDR/DATA      readback byte write port
//   Clk_Conf, SR_In      chip shift clock and serial data
//   SR_RST, LdDAC, LdPix chip shift-register reset and load strobes
//   SR_OUT               chip serial output
//
// Each bit slot is 2*CLK_DIV Clk cycles: Clk_Conf low for the first CLK_DIV
// cycles, high for the rest. SR_In changes on the edge closing slot cycle 1,
// SR_OUT is sampled on the edge closing slot cycle CLK_DIV-1.
module mono_conf_driver #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        Clk,
    input  logic        nRST,
    input  logic        START,
    input  logic        SEL_PIX,
    input  logic        EN_SR_RST,
    input  logic [12:0] NBITS,
    output logic        BUSY,
    output logic        DONE,
    output logic        MEM_RD,
    output logic [9:0]  MEM_ADDR,
    input  logic [7:0]  MEM_DATA,
    output logic        RB_WE,
    output logic [9:0]  RB_ADDR,
    output logic [7:0]  RB_DATA,
    output logic        Clk_Conf,
    output logic        SR_In,
    output logic        SR_RST,
    output logic        LdDAC,
    output logic        LdPix,
    input  logic        SR_OUT
);

    localparam logic [9:0] HALF      = 10'(CLK_DIV);
    localparam logic [9:0] HALF_M1   = 10'(CLK_DIV - 1);
    localparam logic [9:0] SLOT_LAST = 10'(2 * CLK_DIV - 1);
    localparam logic [9:0] LOAD_LAST = 10'(3 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SRRST,
        SHIFT,
        LOAD,
        FINISH
    } state_t;

    state_t      state, state_n;
    logic [9:0]  cyc, cyc_n;
    logic [12:0] bit_cnt, bit_n;
    logic [12:0] nbits_q, nbits_n;
    logic        sel_pix_q, sel_pix_n;

    logic        busy_n, done_n, mem_rd_n, clk_conf_n, sr_rst_n;
    logic        ld_phase, ld_dac_n, ld_pix_n;
    logic [9:0]  mem_addr_n;

    logic [7:0]  data_byte;
    logic [7:0]  rb_acc, rb_next;
    logic        bit_last, byte_last;

    // Next-state logic. Outputs are computed from the *next* state/counters
    // so that every strobe comes straight out of a flop and lines up with
    // the state it belongs to.
    always_comb begin
        state_n   = state;
        cyc_n     = cyc + 10'd1;
        bit_n     = bit_cnt;
        nbits_n   = nbits_q;
        sel_pix_n = sel_pix_q;
        bit_last  = (bit_cnt == nbits_q - 13'd1);

        case (state)
            IDLE: begin
                cyc_n = '0;
                if (START) begin
                    nbits_n   = NBITS;
                    sel_pix_n = SEL_PIX;
                    bit_n     = '0;
                    if (NBITS == '0)
                        state_n = FINISH;
                    else if (EN_SR_RST)
                        state_n = SRRST;
                    else
                        state_n = SHIFT;
                end
            end
            SRRST: begin
                if (cyc == SLOT_LAST) begin
                    state_n = SHIFT;
                    cyc_n   = '0;
                end
            end
            SHIFT: begin
                if (cyc == SLOT_LAST) begin
                    cyc_n = '0;
                    if (bit_last)
                        state_n = LOAD;
                    else
                        bit_n = bit_cnt + 13'd1;
                end
            end
            LOAD: begin
                if (cyc == LOAD_LAST) begin
                    state_n = FINISH;
                    cyc_n   = '0;
                end
            end
            FINISH: begin
                state_n = IDLE;
                cyc_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
            end
        endcase

        busy_n     = (state_n != IDLE);
        done_n     = (state == FINISH);
        mem_rd_n   = (state_n == SHIFT) && (cyc_n == '0) && (bit_n[2:0] == 3'd0);
        mem_addr_n = mem_rd_n ? bit_n[12:3] : MEM_ADDR;
        clk_conf_n = (state_n == SHIFT) && (cyc_n >= HALF);
        sr_rst_n   = (state_n == SRRST);
        ld_phase   = (state_n == LOAD) && (cyc_n >= HALF);
        ld_dac_n   = ld_phase && !sel_pix_n;
        ld_pix_n   = ld_phase && sel_pix_n;
    end

    always_ff @(posedge Clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cyc       <= '0;
            bit_cnt   <= '0;
            nbits_q   <= '0;
            sel_pix_q <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            MEM_RD    <= 1'b0;
            MEM_ADDR  <= '0;
            Clk_Conf  <= 1'b0;
            SR_RST    <= 1'b0;
            LdDAC     <= 1'b0;
            LdPix     <= 1'b0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            bit_cnt   <= bit_n;
            nbits_q   <= nbits_n;
            sel_pix_q <= sel_pix_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            MEM_RD    <= mem_rd_n;
            MEM_ADDR  <= mem_addr_n;
            Clk_Conf  <= clk_conf_n;
            SR_RST    <= sr_rst_n;
            LdDAC     <= ld_dac_n;
            LdPix     <= ld_pix_n;
        end
    end

    // Readback packing: the first bit of a byte clears the accumulator so a
    // short final byte is written with zeros above its last valid bit.
    always_comb begin
        rb_next              = (bit_cnt[2:0] == 3'd0) ? '0 : rb_acc;
        rb_next[bit_cnt[2:0]] = SR_OUT;
        byte_last            = (bit_cnt[2:0] == 3'd7) || bit_last;
    end

    always_ff @(posedge Clk or negedge nRST) begin
        if (!nRST) begin
            data_byte <= '0;
            SR_In     <= 1'b0;
            rb_acc    <= '0;
            RB_WE     <= 1'b0;
            RB_ADDR   <= '0;
            RB_DATA   <= '0;
        end else begin
            RB_WE <= 1'b0;
            if (state == SHIFT && cyc == 10'd1) begin
                // First bit of a byte comes straight from the memory bus,
                // the rest from the captured copy.
                if (bit_cnt[2:0] == 3'd0) begin
                    data_byte <= MEM_DATA;
                    SR_In     <= MEM_DATA[0];
                end else begin
                    SR_In <= data_byte[bit_cnt[2:0]];
                end
            end
            if (state == SHIFT && cyc == HALF_M1) begin
                rb_acc <= rb_next;
                if (byte_last) begin
                    RB_WE   <= 1'b1;
                    RB_ADDR <= bit_cnt[12:3];
                    RB_DATA <= rb_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mono_conf_driver.sv
// Directed testbench for mono_conf_driver (CLK_DIV = 4).
module tb_mono_conf_driver;

    logic        Clk = 1'b0;
    logic        nRST;
    logic        START;
    logic        SEL_PIX;
    logic        EN_SR_RST;
    logic [12:0] NBITS;
    logic        BUSY, DONE, MEM_RD, RB_WE, Clk_Conf, SR_In, SR_RST, LdDAC, LdPix;
    logic [9:0]  MEM_ADDR, RB_ADDR;
    logic [7:0]  MEM_DATA = 8'h00;
    logic [7:0]  RB_DATA;
    logic        SR_OUT;

    int tests  = 0;
    int failed = 0;

    mono_conf_driver #(.CLK_DIV(4)) dut (
        .Clk(Clk), .nRST(nRST), .START(START), .SEL_PIX(SEL_PIX),
        .EN_SR_RST(EN_SR_RST), .NBITS(NBITS), .BUSY(BUSY), .DONE(DONE),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .RB_WE(RB_WE), .RB_ADDR(RB_ADDR), .RB_DATA(RB_DATA),
        .Clk_Conf(Clk_Conf), .SR_In(SR_In), .SR_RST(SR_RST),
        .LdDAC(LdDAC), .LdPix(LdPix), .SR_OUT(SR_OUT)
    );

    always #5 Clk = ~Clk;

    // Source memory
    logic [7:0] mem [0:1023];
    always @(posedge Clk) if (MEM_RD) MEM_DATA <= mem[MEM_ADDR];

    // Chip shift-register model: shifts SR_In in at the top on Clk_Conf rise
    logic [15:0] model_sr = 16'h0000;
    logic [15:0] model_init = 16'h0000;
    logic        model_load = 1'b0;
    always @(posedge Clk_Conf or posedge model_load)
        if (model_load) model_sr <= model_init;
        else            model_sr <= {SR_In, model_sr[15:1]};
    assign SR_OUT = model_sr[0];

    // Activity monitor (cumulative counts, sampled mid-cycle)
    int   cc_rises = 0, srrst_cyc = 0, dac_cyc = 0, pix_cyc = 0;
    int   overlap = 0, done_cnt = 0, rd_cnt = 0;
    logic cc_prev = 1'b0;
    bit         sr_q[$];
    logic [9:0] rb_addr_q[$];
    logic [7:0] rb_data_q[$];

    always @(negedge Clk) begin
        cc_prev <= Clk_Conf;
        if (Clk_Conf && !cc_prev) begin
            cc_rises <= cc_rises + 1;
            sr_q.push_back(SR_In);
        end
        if (SR_RST)         srrst_cyc <= srrst_cyc + 1;
        if (LdDAC)          dac_cyc   <= dac_cyc + 1;
        if (LdPix)          pix_cyc   <= pix_cyc + 1;
        if (LdDAC && LdPix) overlap   <= overlap + 1;
        if (DONE)           done_cnt  <= done_cnt + 1;
        if (MEM_RD)         rd_cnt    <= rd_cnt + 1;
        if (RB_WE) begin
            rb_addr_q.push_back(RB_ADDR);
            rb_data_q.push_back(RB_DATA);
        end
    end

    // Snapshots taken before each transfer
    int b_cc, b_rst, b_dac, b_pix, b_ovl, b_done, b_rd, b_sr, b_rb;

    task automatic snap();
        b_cc = cc_rises; b_rst = srrst_cyc; b_dac = dac_cyc; b_pix = pix_cyc;
        b_ovl = overlap; b_done = done_cnt; b_rd = rd_cnt;
        b_sr = sr_q.size(); b_rb = rb_data_q.size();
    endtask

    task automatic load_model(input logic [15:0] v);
        model_init = v;
        model_load = 1'b1;
        #1;
        model_load = 1'b0;
    endtask

    task automatic start_xfer(input bit sel, input bit en, input logic [12:0] n);
        @(negedge Clk);
        SEL_PIX = sel; EN_SR_RST = en; NBITS = n; START = 1'b1;
        @(negedge Clk);
        START = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clk);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        nRST = 1'b0; START = 1'b0; SEL_PIX = 1'b0; EN_SR_RST = 1'b0; NBITS = '0;
        repeat (3) @(negedge Clk);
        tests++;
        if ({BUSY, DONE, MEM_RD, MEM_ADDR, RB_WE, RB_ADDR, RB_DATA, Clk_Conf,
             SR_In, SR_RST, LdDAC, LdPix} !== 37'd0) begin
            failed++;
            $display("FAIL reset_outputs: got BUSY=%b Clk_Conf=%b SR_RST=%b LdDAC=%b LdPix=%b MEM_RD=%b RB_WE=%b, required all 0",
                     BUSY, Clk_Conf, SR_RST, LdDAC, LdPix, MEM_RD, RB_WE);
        end
        nRST = 1'b1;
        repeat (4) @(negedge Clk);
        tests++;
        if ({BUSY, DONE, MEM_RD, Clk_Conf, SR_RST, LdDAC, LdPix} !== 7'd0) begin
            failed++;
            $display("FAIL idle_after_reset: got BUSY=%b DONE=%b Clk_Conf=%b, required 0", BUSY, DONE, Clk_Conf);
        end
    endtask

    task automatic check_basic_result(input string tag);
        logic [15:0] seq;
        seq = '0;
        tests++;
        if (cc_rises - b_cc !== 16) begin
            failed++;
            $display("FAIL %s_rises: got %0d required 16", tag, cc_rises - b_cc);
        end
        for (int i = 0; i < 16; i++)
            if (b_sr + i < sr_q.size()) seq[i] = sr_q[b_sr + i];
        tests++;
        if (seq !== 16'h3CA5) begin
            failed++;
            $display("FAIL %s_sr_in_seq: got %h required 3ca5 (bit k = slot k)", tag, seq);
        end
        tests++;
        if (done_cnt - b_done !== 1) begin
            failed++;
            $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt - b_done);
        end
    endtask

    task automatic test_basic();
        bit ok;
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        load_model(16'hBEEF);
        snap();
        start_xfer(1'b0, 1'b1, 13'd16);
        wait_done(1000, ok);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL basic_done_timeout: got no DONE required DONE within 1000 cycles");
        end
        check_basic_result("basic");
        tests++;
        if (srrst_cyc - b_rst !== 8) begin
            failed++;
            $display("FAIL basic_sr_rst_cycles: got %0d required 8", srrst_cyc - b_rst);
        end
        tests++;
        if (dac_cyc - b_dac !== 8 || pix_cyc - b_pix !== 0) begin
            failed++;
            $display("FAIL basic_load: got LdDAC=%0d LdPix=%0d cycles required 8 and 0",
                     dac_cyc - b_dac, pix_cyc - b_pix);
        end
        tests++;
        if (rd_cnt - b_rd !== 2) begin
            failed++;
            $display("FAIL basic_mem_rd: got %0d required 2", rd_cnt - b_rd);
        end
        tests++;
        if (rb_data_q.size() - b_rb !== 2) begin
            failed++;
            $display("FAIL basic_rb_count: got %0d required 2", rb_data_q.size() - b_rb);
        end else begin
            tests++;
            if (rb_addr_q[b_rb] !== 10'd0 || rb_data_q[b_rb] !== 8'hEF ||
                rb_addr_q[b_rb+1] !== 10'd1 || rb_data_q[b_rb+1] !== 8'hBE) begin
                failed++;
                $display("FAIL basic_readback: got %0d:%h %0d:%h required 0:ef 1:be",
                         rb_addr_q[b_rb], rb_data_q[b_rb], rb_addr_q[b_rb+1], rb_data_q[b_rb+1]);
            end
        end
        tests++;
        if (BUSY !== 1'b0) begin
            failed++;
            $display("FAIL basic_busy_end: got %b required 0", BUSY);
        end
    endtask

    task automatic test_partial();
        bit ok;
        int bad;
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        load_model(16'hFFFF);
        snap();
        start_xfer(1'b0, 1'b1, 13'd197);
        wait_done(3000, ok);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL partial_done_timeout: got no DONE required DONE within 3000 cycles");
        end
        tests++;
        if (cc_rises - b_cc !== 197) begin
            failed++;
            $display("FAIL partial_rises: got %0d required 197", cc_rises - b_cc);
        end
        tests++;
        if (rd_cnt - b_rd !== 25) begin
            failed++;
            $display("FAIL partial_mem_rd: got %0d required 25", rd_cnt - b_rd);
        end
        tests++;
        if (rb_data_q.size() - b_rb !== 25) begin
            failed++;
            $display("FAIL partial_rb_count: got %0d required 25", rb_data_q.size() - b_rb);
        end else begin
            bad = 0;
            for (int j = 0; j < 24; j++)
                if (rb_data_q[b_rb+j] !== 8'hFF || rb_addr_q[b_rb+j] !== 10'(j)) bad++;
            tests++;
            if (bad != 0) begin
                failed++;
                $display("FAIL partial_full_bytes: got %0d wrong bytes required 0", bad);
            end
            tests++;
            if (rb_data_q[b_rb+24] !== 8'h1F || rb_addr_q[b_rb+24] !== 10'd24) begin
                failed++;
                $display("FAIL partial_last_byte: got %0d:%h required 24:1f",
                         rb_addr_q[b_rb+24], rb_data_q[b_rb+24]);
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        int bad;
        logic [7:0] b;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3) ^ 8'h5A;
        load_model(16'hBEEF);
        snap();
        start_xfer(1'b1, 1'b0, 13'd4644);
        wait_done(40000, ok);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL full_done_timeout: got no DONE required DONE within 40000 cycles");
        end
        tests++;
        if (cc_rises - b_cc !== 4644) begin
            failed++;
            $display("FAIL full_rises: got %0d required 4644", cc_rises - b_cc);
        end
        tests++;
        if (srrst_cyc - b_rst !== 0) begin
            failed++;
            $display("FAIL full_no_sr_rst: got %0d cycles required 0", srrst_cyc - b_rst);
        end
        tests++;
        if (rd_cnt - b_rd !== 581 || MEM_ADDR !== 10'd580) begin
            failed++;
            $display("FAIL full_reads: got %0d reads last addr %0d required 581 and 580", rd_cnt - b_rd, MEM_ADDR);
        end
        tests++;
        if (pix_cyc - b_pix !== 8 || dac_cyc - b_dac !== 0 || overlap - b_ovl !== 0) begin
            failed++;
            $display("FAIL full_load: got LdPix=%0d LdDAC=%0d overlap=%0d required 8 0 0",
                     pix_cyc - b_pix, dac_cyc - b_dac, overlap - b_ovl);
        end
        bad = 0;
        for (int k = 0; k < 4644; k++) begin
            b = mem[k / 8];
            if (b_sr + k >= sr_q.size() || sr_q[b_sr + k] !== b[k % 8]) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL full_sr_in_stream: got %0d wrong bits required 0", bad);
        end
        tests++;
        if (rb_data_q.size() - b_rb !== 581) begin
            failed++;
            $display("FAIL full_rb_count: got %0d required 581", rb_data_q.size() - b_rb);
        end else begin
            bad = 0;
            if (rb_data_q[b_rb] !== 8'hEF || rb_data_q[b_rb+1] !== 8'hBE) bad++;
            for (int j = 2; j < 580; j++)
                if (rb_data_q[b_rb+j] !== mem[j-2] || rb_addr_q[b_rb+j] !== 10'(j)) bad++;
            b = mem[578];
            if (rb_data_q[b_rb+580] !== {4'h0, b[3:0]} || rb_addr_q[b_rb+580] !== 10'd580) bad++;
            tests++;
            if (bad != 0) begin
                failed++;
                $display("FAIL full_readback: got %0d wrong bytes required 0", bad);
            end
        end
    endtask

    task automatic test_zero();
        snap();
        start_xfer(1'b0, 1'b1, 13'd0);
        tests++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            failed++;
            $display("FAIL zero_cycle1: got DONE=%b BUSY=%b required 0 1", DONE, BUSY);
        end
        @(negedge Clk);
        tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            failed++;
            $display("FAIL zero_cycle2: got DONE=%b BUSY=%b required 1 0", DONE, BUSY);
        end
        repeat (3) @(negedge Clk);
        tests++;
        if (cc_rises - b_cc !== 0 || dac_cyc - b_dac !== 0 || pix_cyc - b_pix !== 0 ||
            srrst_cyc - b_rst !== 0 || done_cnt - b_done !== 1) begin
            failed++;
            $display("FAIL zero_activity: got rises=%0d dac=%0d pix=%0d rst=%0d done=%0d required 0 0 0 0 1",
                     cc_rises - b_cc, dac_cyc - b_dac, pix_cyc - b_pix, srrst_cyc - b_rst, done_cnt - b_done);
        end
    endtask

    task automatic test_abort();
        bit ok;
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        snap();
        start_xfer(1'b0, 1'b0, 13'd16);
        // second request while busy must be ignored
        SEL_PIX = 1'b1; NBITS = 13'd0; START = 1'b1;
        @(negedge Clk);
        START = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (cc_rises - b_cc >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || done_cnt - b_done !== 0) begin
            failed++;
            $display("FAIL abort_reach_slot5: got reached=%0d done=%0d required 1 0", ok, done_cnt - b_done);
        end
        nRST = 1'b0;
        #1;
        tests++;
        if ({BUSY, DONE, MEM_RD, MEM_ADDR, RB_WE, RB_ADDR, RB_DATA, Clk_Conf,
             SR_In, SR_RST, LdDAC, LdPix} !== 37'd0) begin
            failed++;
            $display("FAIL abort_immediate_zero: got BUSY=%b Clk_Conf=%b SR_In=%b MEM_ADDR=%0d, required all 0",
                     BUSY, Clk_Conf, SR_In, MEM_ADDR);
        end
        snap();
        repeat (5) @(negedge Clk);
        nRST = 1'b1;
        repeat (6) @(negedge Clk);
        tests++;
        if (cc_rises - b_cc !== 0 || dac_cyc - b_dac !== 0 || pix_cyc - b_pix !== 0 ||
            done_cnt - b_done !== 0 || BUSY !== 1'b0) begin
            failed++;
            $display("FAIL abort_quiet: got rises=%0d dac=%0d pix=%0d done=%0d busy=%b required 0 0 0 0 0",
                     cc_rises - b_cc, dac_cyc - b_dac, pix_cyc - b_pix, done_cnt - b_done, BUSY);
        end
        snap();
        start_xfer(1'b0, 1'b1, 13'd16);
        wait_done(1000, ok);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL abort_rerun_timeout: got no DONE required DONE within 1000 cycles");
        end
        check_basic_result("rerun");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero();
        test_abort();
        test_full();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no end of run required end within 5 ms");
        $fatal(1);
    end

endmodule
